fetch_unit: RTL



---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I fetch stage: FSM states,
// in-flight tag and buffered-instruction layouts.
package fetch_unit_pkg;

  // Max (in-flight requests + buffered words).
  localparam int unsigned FETCH_DEPTH = 2;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  // Kill flag sits in bit 0 so the queue can broadcast-kill without knowing the layout.
  typedef struct packed {
    logic [31:0] pc;
    logic        kill;
  } fetch_tag_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_buf_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory request/response, redirect input and
// decode-side instruction handshake.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
           inst_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry synchronous FIFO with flush; optional broadcast kill sets bit 0
// of every stored entry (used by the in-flight tag queue).
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter bit          KILL_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             kill_all,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [FETCH_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FETCH_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      // Kill is applied before the push so a freshly written entry keeps its own flag.
      for (int unsigned i = 0; i < FETCH_DEPTH; i++) begin
        if (KILL_EN && kill_all) mem_q[i][0] <= 1'b1;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC, up to two in-flight word fetches, 2-entry
// instruction buffer, redirect flush. Define FETCH_MISALIGN_CHECK_EN to fault on misaligned redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic         misaligned;
  logic         req_valid;
  logic         req_fire;
  logic         resp_keep;
  logic         inst_fire;
  logic [1:0]   tag_count;
  logic [1:0]   buf_count;
  fetch_tag_t   tag_head, tag_push;
  fetch_buf_t   buf_head, buf_push;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    case (state_q)
      FETCH_BOOT:  state_d = FETCH_RUN;
      FETCH_RUN:   if (bus.redirect_valid && misaligned) state_d = FETCH_FAULT;
      FETCH_FAULT: if (bus.redirect_valid && !misaligned) state_d = FETCH_RUN;
      default:     state_d = FETCH_BOOT;
    endcase
    // Credits cover both in-flight and buffered words, so the buffer can never overflow.
    if (state_q == FETCH_RUN && !bus.redirect_valid &&
        ({1'b0, tag_count} + {1'b0, buf_count} < 3'd2))
      req_valid = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  pc_q <= RESET_PC;
    else if (bus.redirect_valid) pc_q <= align_pc(bus.redirect_pc);
    else if (req_fire)           pc_q <= pc_q + 32'd4;
  end

  assign req_fire           = req_valid & bus.imem_req_ready;
  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;

  assign tag_push = '{pc: pc_q, kill: 1'b0};

  fetch_unit_fifo #(
    .WIDTH   ($bits(fetch_tag_t)),
    .KILL_EN (1'b1)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (tag_push),
    .pop       (bus.imem_resp_valid),
    .kill_all  (bus.redirect_valid),
    .head      (tag_head),
    .count     (tag_count)
  );

  // A response landing in the redirect cycle is killed along with the queued tags.
  assign resp_keep = bus.imem_resp_valid & ~tag_head.kill & ~bus.redirect_valid;
  assign buf_push  = '{data: bus.imem_resp_data, pc: tag_head.pc};

  fetch_unit_fifo #(
    .WIDTH   ($bits(fetch_buf_t)),
    .KILL_EN (1'b0)
  ) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (resp_keep),
    .push_data (buf_push),
    .pop       (inst_fire),
    .kill_all  (1'b0),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign bus.inst_valid = (buf_count != 2'd0) & ~bus.redirect_valid;
  assign bus.inst       = buf_head.data;
  assign bus.inst_pc    = buf_head.pc;
  assign inst_fire      = bus.inst_valid & bus.inst_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.fetch_fault = (state_q == FETCH_FAULT);
`else
  assign bus.fetch_fault = 1'b0;
`endif

  resp_without_request: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_resp_valid |-> (tag_count != 2'd0)
  );

endmodule
